// File: rtl/mips_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_fetch_pkg
// Purpose  : Shared encodings for the MIPS instruction-fetch stage:
//            decoder control_type codes, fetch FSM states, default reset PC.
// Revision : 1.0  initial release
// ============================================================================
package mips_fetch_pkg;

    // control_type codes produced by mips_decode
    localparam logic [1:0] CT_FALL   = 2'b00;
    localparam logic [1:0] CT_BRANCH = 2'b01;
    localparam logic [1:0] CT_JUMP   = 2'b10;
    localparam logic [1:0] CT_JR     = 2'b11;

    // Fetch FSM states
    typedef enum logic [1:0] {
        FETCH = 2'b00,
        ISSUE = 2'b01,
        HALT  = 2'b10
    } fetch_state_t;

    // Default MIPS user text segment start
    localparam logic [31:0] C_DEFAULT_RESET_PC = 32'h0040_0000;

endpackage : mips_fetch_pkg
`default_nettype wire

// File: rtl/mips_next_pc.sv
`default_nettype none
// ============================================================================
// Module   : mips_next_pc
// Purpose  : Combinational next-PC selection for the fetch stage, plus the
//            misaligned-jr detection that halts the machine.
// Revision : 1.0  initial release
// ============================================================================
module mips_next_pc
    import mips_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [25:0]       i_jump_index,
    input  logic [1:0]        i_control_type,
    input  logic [31:0]       i_branch_offset,
    input  logic [31:0]       i_jr_target,
    output logic [ADDR_W-1:0] o_next_pc,
    output logic              o_misaligned
);

    logic [ADDR_W-1:0] w_pc_plus4;

    assign w_pc_plus4 = i_pc + ADDR_W'(4);

    // A jr target must be word aligned; anything else stops the machine.
    assign o_misaligned = (i_control_type == CT_JR) && (i_jr_target[1:0] != 2'b00);

    // Select the successor address; all arithmetic wraps at the address width.
    always_comb begin
        o_next_pc = w_pc_plus4;
        unique case (i_control_type)
            CT_FALL:   o_next_pc = w_pc_plus4;
            CT_BRANCH: o_next_pc = w_pc_plus4 + ADDR_W'(i_branch_offset << 2);
            CT_JUMP:   o_next_pc = {w_pc_plus4[ADDR_W-1:28], i_jump_index, 2'b00};
            CT_JR:     o_next_pc = ADDR_W'(i_jr_target);
            default:   o_next_pc = w_pc_plus4;
        endcase
    end

endmodule : mips_next_pc
`default_nettype wire

// File: rtl/mips_fetch.sv
`default_nettype none
// ============================================================================
// Module   : mips_fetch
// Purpose  : Instruction-fetch stage. Holds the PC, fetches one word over a
//            req/ready handshake, presents it to decode/execute, and advances
//            the PC when execute acknowledges. Exceptions and misaligned jr
//            targets park the machine in HALT until reset.
// Revision : 1.0  initial release
// ============================================================================
module mips_fetch
    import mips_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(C_DEFAULT_RESET_PC)
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       inst,
    output logic              inst_valid,
    input  logic              inst_ack,
    input  logic [1:0]        control_type,
    input  logic [31:0]       branch_offset,
    input  logic [31:0]       jr_target,
    input  logic              except,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              misaligned
);

    fetch_state_t      r_state_q;
    fetch_state_t      w_state_d;
    logic [ADDR_W-1:0] r_pc_q;
    logic [ADDR_W-1:0] w_pc_d;
    logic [31:0]       r_inst_q;
    logic [31:0]       w_inst_d;
    logic              r_misaligned_q;
    logic              w_misaligned_d;

    logic [ADDR_W-1:0] w_next_pc;
    logic              w_jr_misaligned;

    mips_next_pc #(
        .ADDR_W (ADDR_W)
    ) u_next_pc (
        .i_pc            (r_pc_q),
        .i_jump_index    (r_inst_q[25:0]),
        .i_control_type  (control_type),
        .i_branch_offset (branch_offset),
        .i_jr_target     (jr_target),
        .o_next_pc       (w_next_pc),
        .o_misaligned    (w_jr_misaligned)
    );

    // Next-state logic: capture the fetched word, then advance PC or halt on ack.
    always_comb begin
        w_state_d      = r_state_q;
        w_pc_d         = r_pc_q;
        w_inst_d       = r_inst_q;
        w_misaligned_d = r_misaligned_q;
        unique case (r_state_q)
            FETCH: begin
                if (imem_ready) begin
                    w_inst_d  = imem_rdata;
                    w_state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (inst_ack) begin
                    if (except) begin
                        w_state_d = HALT;
                    end else if (w_jr_misaligned) begin
                        w_state_d      = HALT;
                        w_misaligned_d = 1'b1;
                    end else begin
                        w_pc_d    = w_next_pc;
                        w_state_d = FETCH;
                    end
                end
            end
            HALT: begin
                w_state_d = HALT;
            end
            default: begin
                w_state_d = HALT;
            end
        endcase
    end

    // State and datapath registers; reset abandons any outstanding fetch.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q      <= FETCH;
            r_pc_q         <= RESET_PC;
            r_inst_q       <= 32'h0;
            r_misaligned_q <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_pc_q         <= w_pc_d;
            r_inst_q       <= w_inst_d;
            r_misaligned_q <= w_misaligned_d;
        end
    end

    assign imem_req   = (r_state_q == FETCH);
    assign imem_addr  = r_pc_q;
    assign inst_valid = (r_state_q == ISSUE);
    assign halted     = (r_state_q == HALT);
    assign inst       = r_inst_q;
    assign pc         = r_pc_q;
    assign misaligned = r_misaligned_q;

endmodule : mips_fetch
`default_nettype wire

// File: tb/tb_mips_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_fetch
// Purpose  : Self-checking bench for mips_fetch: directed scenarios with
//            literal expectations plus randomized traffic compared every
//            cycle against a behavioural model of the fetch stage.
// Revision : 1.0  initial release
// ============================================================================
module tb_mips_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        inst_ack = 1'b0;
    logic [1:0]  control_type = 2'b00;
    logic [31:0] branch_offset = 32'h0;
    logic [31:0] jr_target = 32'h0;
    logic        except = 1'b0;

    logic [31:0] imem_addr, inst, pc;
    logic        imem_req, inst_valid, halted, misaligned;

    // second instance: reset vector at the top of the address space
    logic        rst2 = 1'b1;
    logic        ready2 = 1'b0;
    logic        ack2 = 1'b0;
    logic [31:0] imem_addr2, inst2, pc2;
    logic        imem_req2, inst_valid2, halted2, misaligned2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mips_fetch #(.ADDR_W(32), .RESET_PC(32'h0040_0000)) dut (
        .clock(clk), .reset(rst),
        .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .inst(inst), .inst_valid(inst_valid), .inst_ack(inst_ack),
        .control_type(control_type), .branch_offset(branch_offset),
        .jr_target(jr_target), .except(except),
        .pc(pc), .halted(halted), .misaligned(misaligned)
    );

    mips_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clock(clk), .reset(rst2),
        .imem_addr(imem_addr2), .imem_req(imem_req2),
        .imem_ready(ready2), .imem_rdata(32'h1234_5678),
        .inst(inst2), .inst_valid(inst_valid2), .inst_ack(ack2),
        .control_type(2'b00), .branch_offset(32'h0),
        .jr_target(32'h0), .except(1'b0),
        .pc(pc2), .halted(halted2), .misaligned(misaligned2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: the machine is either waiting on memory, waiting
    // on execute, or stopped; PC successors computed with plain arithmetic.
    // ------------------------------------------------------------------
    localparam int P_WAIT_MEM  = 0;
    localparam int P_WAIT_EXEC = 1;
    localparam int P_STOPPED   = 2;

    int          m_phase = P_WAIT_MEM;
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_inst  = 32'h0;
    logic        m_mis   = 1'b0;
    bit          m_live  = 1'b0;

    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] ins,
                                               input logic [1:0] ct, input logic [31:0] bo,
                                               input logic [31:0] jr);
        logic [31:0] seq;
        seq = cur + 32'd4;
        case (ct)
            2'd0: return seq;
            2'd1: return seq + bo * 32'd4;
            2'd2: return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
            default: return jr;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase = P_WAIT_MEM;
            m_pc    = 32'h0040_0000;
            m_inst  = 32'h0;
            m_mis   = 1'b0;
            m_live  = 1'b1;
        end else if (m_live) begin
            if (m_phase == P_WAIT_MEM) begin
                if (imem_ready) begin
                    m_inst  = imem_rdata;
                    m_phase = P_WAIT_EXEC;
                end
            end else if (m_phase == P_WAIT_EXEC) begin
                if (inst_ack) begin
                    if (except) begin
                        m_phase = P_STOPPED;
                    end else if (control_type == 2'd3 && (jr_target % 4) != 0) begin
                        m_phase = P_STOPPED;
                        m_mis   = 1'b1;
                    end else begin
                        m_pc    = model_next(m_pc, m_inst, control_type, branch_offset, jr_target);
                        m_phase = P_WAIT_MEM;
                    end
                end
            end
        end
    end

    // Compare every cycle on the falling edge once the model is initialised.
    always @(negedge clk) begin
        if (m_live) begin
            check("cyc_imem_req",   {31'h0, imem_req},   {31'h0, m_phase == P_WAIT_MEM});
            check("cyc_imem_addr",  imem_addr,           m_pc);
            check("cyc_inst_valid", {31'h0, inst_valid}, {31'h0, m_phase == P_WAIT_EXEC});
            check("cyc_halted",     {31'h0, halted},     {31'h0, m_phase == P_STOPPED});
            check("cyc_inst",       inst,                m_inst);
            check("cyc_pc",         pc,                  m_pc);
            check("cyc_misaligned", {31'h0, misaligned}, {31'h0, m_mis});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; imem_ready = 1'b0; inst_ack = 1'b0; except = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic fetch_word(input logic [31:0] w);
        imem_ready = 1'b1; imem_rdata = w;
        tick();
        imem_ready = 1'b0;
    endtask

    task automatic ack(input logic [1:0] ct, input logic [31:0] bo, input logic [31:0] jr, input logic exc);
        inst_ack = 1'b1; control_type = ct; branch_offset = bo; jr_target = jr; except = exc;
        tick();
        inst_ack = 1'b0; except = 1'b0;
    endtask

    initial begin
        tick();
        do_reset();
        // Reset state
        check("rst_pc",        pc,                 32'h0040_0000);
        check("rst_req",       {31'h0, imem_req},  32'h1);
        check("rst_inst",      inst,               32'h0);
        check("rst_halted",    {31'h0, halted},    32'h0);

        // 1: single fallthrough instruction
        check("t1_addr", imem_addr, 32'h0040_0000);
        fetch_word(32'h2008_0005);
        check("t1_inst",  inst, 32'h2008_0005);
        check("t1_valid", {31'h0, inst_valid}, 32'h1);
        check("t1_req0",  {31'h0, imem_req},   32'h0);
        ack(2'b00, 32'h0, 32'h0, 1'b0);
        check("t1_pc",  pc, 32'h0040_0004);
        check("t1_req", {31'h0, imem_req}, 32'h1);

        // 2: memory stalls for 3 cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_req",   {31'h0, imem_req},   32'h1);
            check("t2_addr",  imem_addr,           32'h0040_0004);
            check("t2_valid", {31'h0, inst_valid}, 32'h0);
        end
        fetch_word(32'h0000_0020);
        check("t2_issue", {31'h0, inst_valid}, 32'h1);

        // 3: advance to 0x00400010, then branch back and jump
        ack(2'b00, 32'h0, 32'h0, 1'b0);
        fetch_word(32'h0); ack(2'b00, 32'h0, 32'h0, 1'b0);
        fetch_word(32'h0); ack(2'b00, 32'h0, 32'h0, 1'b0);
        check("t3_pc0", pc, 32'h0040_0010);
        fetch_word(32'h1000_FFFE);
        ack(2'b01, 32'hFFFF_FFFE, 32'h0, 1'b0);
        check("t3_branch", pc, 32'h0040_000C);
        fetch_word(32'h0810_0003);
        ack(2'b10, 32'h0, 32'h0, 1'b0);
        check("t3_jump", pc, 32'h0040_000C);

        // 4: jr aligned, then jr misaligned
        fetch_word(32'h0000_0008);
        ack(2'b11, 32'h0, 32'h0040_0020, 1'b0);
        check("t4_jr", pc, 32'h0040_0020);
        fetch_word(32'h0000_0008);
        ack(2'b11, 32'h0, 32'h0040_0022, 1'b0);
        check("t4_halt", {31'h0, halted},     32'h1);
        check("t4_mis",  {31'h0, misaligned}, 32'h1);
        check("t4_pc",   pc, 32'h0040_0020);
        tick(); tick();
        check("t4_noreq", {31'h0, imem_req}, 32'h0);

        // 5: exception at 0x00400008, inputs ignored while halted
        do_reset();
        fetch_word(32'h0); ack(2'b00, 32'h0, 32'h0, 1'b0);
        fetch_word(32'h0); ack(2'b00, 32'h0, 32'h0, 1'b0);
        fetch_word(32'h0000_000C);
        ack(2'b00, 32'h0, 32'h0, 1'b1);
        check("t5_halt", {31'h0, halted},     32'h1);
        check("t5_pc",   pc,                  32'h0040_0008);
        check("t5_mis",  {31'h0, misaligned}, 32'h0);
        fetch_word(32'hAAAA_5555);
        ack(2'b11, 32'h0, 32'h0, 1'b0);
        check("t5_still_pc",   pc,   32'h0040_0008);
        check("t5_still_inst", inst, 32'h0000_000C);
        check("t5_still_halt", {31'h0, halted}, 32'h1);
        do_reset();
        check("t5_rst_pc",  pc, 32'h0040_0000);
        check("t5_rst_req", {31'h0, imem_req}, 32'h1);

        // 6a: PC wrap on the second instance
        rst2 = 1'b1; tick(); rst2 = 1'b0;
        check("t6_pc_top", pc2, 32'hFFFF_FFFC);
        ready2 = 1'b1; tick(); ready2 = 1'b0;
        check("t6_inst2", inst2, 32'h1234_5678);
        check("t6_valid2", {31'h0, inst_valid2}, 32'h1);
        ack2 = 1'b1; tick(); ack2 = 1'b0;
        check("t6_wrap", pc2, 32'h0000_0000);
        check("t6_req2", {30'h0, imem_req2, halted2 | misaligned2}, 32'h2);

        // 6b: reset arriving with imem_ready in FETCH
        fetch_word(32'h0); ack(2'b00, 32'h0, 32'h0, 1'b0);
        rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        rst = 1'b0; imem_ready = 1'b0;
        check("t6_inst0", inst, 32'h0);
        check("t6_pc",    pc,   32'h0040_0000);
        check("t6_valid", {31'h0, inst_valid}, 32'h0);

        // Randomized traffic checked by the model each cycle
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] r;
            r = $urandom;
            rst        = (halted && (r[3:0] < 4'd6)) || (r[9:0] == 10'd0);
            imem_ready = r[4];
            imem_rdata = {$urandom} ;
            inst_ack   = r[5] | r[6];
            control_type = r[8:7];
            branch_offset = (r[10]) ? 32'h0 - 32'($urandom_range(64, 0)) : 32'($urandom_range(64, 0));
            jr_target  = {$urandom} & ((r[15:12] == 4'd0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            except     = (r[20:16] == 5'd0);
            tick();
        end
        rst = 1'b0; imem_ready = 1'b0; inst_ack = 1'b0; except = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mips_fetch
`default_nettype wire
